mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle control unit that sits directly downstream of the instruction-fetch unit.
- Latches the fetched word (instr) into an internal instruction register.
- Sequences each instruction through FETCH/DECODE/EXE/MEM/WB.
- Drives the fetch unit's PC-update selects (npc_sel, j, jal, jr) plus a pc_wr strobe, and the datapath controls (regfile, ALU, extender, data memory).
- Supported ISA subset: addu, subu, ori, lui, lw, sw, beq, j, jal, jr.

Parameters:
- IR_RESET, 32'h0000_0000, instruction-register value after reset.
- RA_IDX, 5'd31, link register index; informational only, exported through the package.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- instr  input  32  instruction word from the fetch unit.
- ir  output  32  latched instruction register.
- state  output  3  current FSM state.
- ir_wr  output  1  IR load strobe.
- pc_wr  output  1  PC update strobe.
- npc_sel  output  1  branch select; the fetch unit ANDs it with ALU zero.
- j  output  1  jump select.
- jal  output  1  jump-and-link select.
- jr  output  1  jump-register select.
- reg_wr  output  1  register-file write enable.
- reg_dst  output  2  destination: 0 = rt, 1 = rd, 2 = $31.
- wb_sel  output  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- alu_src  output  1  ALU operand B: 0 = rt, 1 = extended imm.
- ext_op  output  2  extender: 0 = zero-extend, 1 = sign-extend, 2 = imm<<16.
- alu_op  output  2  ALU function: 0 = add, 1 = sub, 2 = or.
- mem_wr  output  1  data-memory write enable.
- illegal  output  1  sticky undefined-opcode flag (optional feature only, else tied 0).

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5-7 go to FETCH on the next edge with all strobes 0.
- Reset (reset=0) takes effect immediately:
  - state=FETCH, ir=IR_RESET, illegal=0.
  - All strobes forced 0 while reset is low, including ir_wr.
  - After release, FETCH resumes normally.
- Reset mid-instruction abandons it; no pc_wr, reg_wr or mem_wr is issued for it.
- Outputs are combinational from (state, ir). ir is loaded from instr on the rising edge ending FETCH.
- Decode classes: R (op 0) by funct 0x21 addu, 0x23 subu, 0x08 jr; op 0x0d ori, 0x0f lui, 0x23 lw, 0x2b sw, 0x04 beq, 0x02 j, 0x03 jal. Anything else is undefined.
- FETCH: ir_wr=1 -> DECODE.
- DECODE:
  - j: pc_wr=1, j=1 -> FETCH.
  - jal: pc_wr=1, jal=1, reg_wr=1, reg_dst=2, wb_sel=2 -> FETCH.
  - jr: pc_wr=1, jr=1 -> FETCH.
  - Undefined: pc_wr=1 (executes as nop) -> FETCH.
  - All other classes -> EXE.
- EXE:
  - beq: alu_op=sub, alu_src=0, npc_sel=1, pc_wr=1 -> FETCH.
  - lw/sw: alu_op=add, alu_src=1, ext_op=1 -> MEM.
  - addu/subu/ori/lui -> WB.
- MEM:
  - sw: mem_wr=1, pc_wr=1 -> FETCH.
  - lw -> WB.
  - ALU/ext/alu_src controls are held from EXE.
- WB: reg_wr=1, pc_wr=1.
  - addu: reg_dst=1, alu_op=add.
  - subu: reg_dst=1, alu_op=sub.
  - ori: reg_dst=0, alu_src=1, ext_op=0, alu_op=or.
  - lui: reg_dst=0, alu_src=1, ext_op=2, alu_op=or.
  - lw: reg_dst=0, wb_sel=1.
  - Then -> FETCH.
- Cycles per instruction: j/jal/jr/undefined 2; beq 3; addu/subu/ori/lui/sw 4; lw 5.
- Each instruction asserts pc_wr in exactly one cycle, its last. Any select not listed for a state is 0.

Optional Feature:
- Macro: MC_CTRL_UNDEF_TRAP_EN.
- Defined: an undefined opcode in DECODE sets illegal=1 and moves to a HALT state (code 5). HALT drives all strobes 0 and is left only by reset.
- Not defined: undefined opcodes execute as a 2-cycle nop as above, and illegal is tied 0.

Decomposition:
- Package mc_pkg holds:
  - opcode and funct constants;
  - state encodings;
  - reg_dst, wb_sel, ext_op and alu_op encodings;
  - RA_IDX.
- One natural sub-module, mc_decode: combinational mapping of ir to a one-hot instruction class. mc_ctrl keeps the FSM, the IR and the output logic.

Test Plan:
- addu 0x00221821 after reset release -> states 0,1,2,4; ir=0x00221821 from the 2nd cycle; WB has reg_wr=1, reg_dst=1, wb_sel=0, alu_op=0, pc_wr=1; 4 cycles.
- lw 0x8E080004 -> 5 cycles; MEM has mem_wr=0, pc_wr=0; WB has reg_wr=1, reg_dst=0, wb_sel=1; ext_op=1 held in EXE and MEM.
- beq 0x10220003 -> 3 cycles; EXE has npc_sel=1, alu_op=1, pc_wr=1; reg_wr and mem_wr stay 0 throughout.
- jal 0x0C000C10 -> DECODE has pc_wr=1, jal=1, reg_wr=1, reg_dst=2, wb_sel=2; back in FETCH next cycle.
- sw 0xAE080000 with reset pulsed low during MEM -> mem_wr never 1; state=0 and ir=0 immediately; the next instruction fetches normally.
- Opcode 0xFC000000:
  - Macro off: 2-cycle nop with pc_wr=1 in DECODE.
  - Macro on: illegal=1, state=5; no strobes for 10 cycles; reset clears illegal.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, functs,
// FSM state codes, datapath select encodings and the decoded class vector.
package mc_pkg;

  localparam logic [4:0] RA_IDX = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;

  // One-hot instruction class; exactly one field is set for any ir.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic und;
  } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: ir -> one-hot class vector.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ir,
  output cls_t        cls
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = ir[31:26];
  assign fn          = ir[5:0];
  assign unused_bits = ^ir[25:6];

  // Map opcode/funct to a single class bit; anything unknown is und.
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls.und  = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.und = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: instruction register, FETCH/DECODE/EXE/MEM/WB
// sequencer and combinational datapath/PC controls.
// Optional: MC_CTRL_UNDEF_TRAP_EN makes undefined opcodes set a sticky
// illegal flag and park the FSM in HALT until reset.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  output logic [2:0]  state,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        npc_sel,
  output logic        j,
  output logic        jal,
  output logic        jr,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [1:0]  alu_op,
  output logic        mem_wr,
  output logic        illegal
);

  state_t st, st_nxt;
  cls_t   cls;

  assign state = st;

  mc_decode u_dec (
    .ir  (ir),
    .cls (cls)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_FETCH;
    else        st <= st_nxt;
  end

  // Instruction register, captured on the edge that ends FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              ir <= IR_RESET;
    else if (st == S_FETCH)  ir <= instr;
  end

`ifdef MC_CTRL_UNDEF_TRAP_EN
  // Sticky trap flag, set when an undefined opcode is decoded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          illegal <= 1'b0;
    else if (st == S_DECODE && cls.und)  illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Next-state sequencing; unused codes fall back to FETCH.
  always_comb begin
    st_nxt = S_FETCH;
    case (st)
      S_FETCH:  st_nxt = S_DECODE;
      S_DECODE: begin
        if (cls.und) begin
`ifdef MC_CTRL_UNDEF_TRAP_EN
          st_nxt = S_HALT;
`else
          st_nxt = S_FETCH;
`endif
        end else if (cls.j || cls.jal || cls.jr) st_nxt = S_FETCH;
        else                                      st_nxt = S_EXE;
      end
      S_EXE: begin
        if (cls.beq)               st_nxt = S_FETCH;
        else if (cls.lw || cls.sw) st_nxt = S_MEM;
        else                       st_nxt = S_WB;
      end
      S_MEM:    st_nxt = cls.lw ? S_WB : S_FETCH;
      S_WB:     st_nxt = S_FETCH;
`ifdef MC_CTRL_UNDEF_TRAP_EN
      S_HALT:   st_nxt = S_HALT;
`endif
      default:  st_nxt = S_FETCH;
    endcase
  end

  // Control outputs; everything is held low while reset is asserted so a
  // reset mid-instruction never leaks a write strobe.
  always_comb begin
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    npc_sel = 1'b0;
    j       = 1'b0;
    jal     = 1'b0;
    jr      = 1'b0;
    reg_wr  = 1'b0;
    reg_dst = DST_RT;
    wb_sel  = WB_ALU;
    alu_src = 1'b0;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    mem_wr  = 1'b0;
    if (reset) begin
      case (st)
        S_FETCH: ir_wr = 1'b1;
        S_DECODE: begin
          if (cls.j) begin
            pc_wr = 1'b1;
            j     = 1'b1;
          end else if (cls.jal) begin
            pc_wr   = 1'b1;
            jal     = 1'b1;
            reg_wr  = 1'b1;
            reg_dst = DST_RA;
            wb_sel  = WB_PC4;
          end else if (cls.jr) begin
            pc_wr = 1'b1;
            jr    = 1'b1;
          end else if (cls.und) begin
`ifndef MC_CTRL_UNDEF_TRAP_EN
            pc_wr = 1'b1;
`endif
          end
        end
        S_EXE: begin
          if (cls.beq) begin
            alu_op  = ALU_SUB;
            npc_sel = 1'b1;
            pc_wr   = 1'b1;
          end else if (cls.lw || cls.sw) begin
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
          end
        end
        S_MEM: begin
          alu_op  = ALU_ADD;
          alu_src = 1'b1;
          ext_op  = EXT_SIGN;
          if (cls.sw) begin
            mem_wr = 1'b1;
            pc_wr  = 1'b1;
          end
        end
        S_WB: begin
          reg_wr = 1'b1;
          pc_wr  = 1'b1;
          if (cls.addu) begin
            reg_dst = DST_RD;
            alu_op  = ALU_ADD;
          end else if (cls.subu) begin
            reg_dst = DST_RD;
            alu_op  = ALU_SUB;
          end else if (cls.ori) begin
            alu_src = 1'b1;
            ext_op  = EXT_ZERO;
            alu_op  = ALU_OR;
          end else if (cls.lui) begin
            alu_src = 1'b1;
            ext_op  = EXT_LUI;
            alu_op  = ALU_OR;
          end else if (cls.lw) begin
            wb_sel = WB_MEM;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
